// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : seg7_pkg
//  Purpose : Shared definitions for the 4-digit seven-segment scanner:
//            digit count, scan phase encoding, active configuration record
//            and the hex-to-segment lookup table (active-low, CA..CG).
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  // Scan phase within one digit slot
  localparam logic [0:0] PH_BLANK = 1'b0;
  localparam logic [0:0] PH_SHOW  = 1'b1;

  // Segment bit order: [6]=CA (a) ... [0]=CG (g); 0 = segment lit
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  typedef struct packed {
    logic [15:0]           value;
    logic [NUM_DIGITS-1:0] dp;
    logic [NUM_DIGITS-1:0] en;
  } disp_cfg_t;

endpackage
`default_nettype wire

// File: rtl/seg7_hex_dec.sv
`default_nettype none
// ============================================================================
//  Module  : seg7_hex_dec
//  Purpose : Combinational hex nibble to active-low seven-segment decoder.
//  Ports   : nibble - 4-bit hex digit
//            seg    - segments {CA,CB,CC,CD,CE,CF,CG}, 0 = lit
//  Rev     : 1.0  initial release
// ============================================================================
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
//  Module  : seg7_scan
//  Purpose : Time-multiplexed driver for a 4-digit common-anode display.
//            Each digit owns a slot of TICKS_PER_DIGIT cycles whose first
//            BLANK_TICKS cycles are dark (ghosting suppression). New content
//            is double-buffered and only takes effect at a frame boundary.
//  Ports   : clk, reset     - clock, synchronous active-high reset
//            value[15:0]    - nibble i shown on digit i
//            dp_in[3:0]     - decimal point request per digit (1 = lit)
//            en_in[3:0]     - digit enable mask (1 = shown)
//            load           - strobe capturing value/dp_in/en_in as pending
//            frame_done     - one-cycle pulse after each frame boundary
//            AN0..AN3       - digit anodes, active-low
//            CA..CG, DP     - segments and decimal point, active-low
//  Rev     : 1.0  initial release
// ============================================================================
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = 50000,
  parameter int BLANK_TICKS     = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  en_in,
  input  logic        load,
  output logic        frame_done,
  output logic        AN0,
  output logic        AN1,
  output logic        AN2,
  output logic        AN3,
  output logic        CA,
  output logic        CB,
  output logic        CC,
  output logic        CD,
  output logic        CE,
  output logic        CF,
  output logic        CG,
  output logic        DP
);

  localparam int                CNT_W      = $clog2(TICKS_PER_DIGIT);
  localparam int                IDX_W      = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TICKS_PER_DIGIT - 1);
  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [0:0]            phase;
  disp_cfg_t             active;
  disp_cfg_t             pending;
  logic                  pending_valid;

  logic                  wrap;
  logic                  boundary;
  logic [6:0]            dec_seg;
  logic [NUM_DIGITS-1:0] an_next;
  logic [6:0]            seg_next;
  logic                  dp_next;

  logic [NUM_DIGITS-1:0] an;
  logic [6:0]            seg;
  logic                  dp;

  assign wrap     = (cnt == CNT_LAST);
  assign boundary = wrap && (idx == IDX_LAST);

  seg7_hex_dec u_hex_dec (
    .nibble (active.value[{idx, 2'b00} +: 4]),
    .seg    (dec_seg)
  );

  // Next pin values derived from the current scan state; registered below
  always_comb begin
    an_next  = '1;
    seg_next = '1;
    dp_next  = 1'b1;
    if (phase == PH_SHOW && active.en[idx]) begin
      an_next[idx] = 1'b0;
      seg_next     = dec_seg;
      dp_next      = ~active.dp[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      idx           <= '0;
      phase         <= PH_BLANK;
      active        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      frame_done    <= 1'b0;
      an            <= '1;
      seg           <= '1;
      dp            <= 1'b1;
    end else begin
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
      if (wrap) begin
        idx <= idx + IDX_W'(1);
      end

      // Phase register tracks (next cnt >= BLANK_TICKS)
      if (wrap) begin
        phase <= PH_BLANK;
      end else if (cnt == BLANK_LAST) begin
        phase <= PH_SHOW;
      end

      if (boundary && pending_valid) begin
        active        <= pending;
        pending_valid <= 1'b0;
      end
      // A load on the boundary cycle is written after the transfer above,
      // so the transfer sees the older pending data and the new data stays
      // pending for the following frame.
      if (load) begin
        pending       <= '{value: value, dp: dp_in, en: en_in};
        pending_valid <= 1'b1;
      end

      frame_done <= boundary;
      an         <= an_next;
      seg        <= seg_next;
      dp         <= dp_next;
    end
  end

  assign {AN3, AN2, AN1, AN0}          = an;
  assign {CA, CB, CC, CD, CE, CF, CG}  = seg;
  assign DP                            = dp;

endmodule
`default_nettype wire
